// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider. Each channel produces a registered divided
// clock and a one-cycle tick at the start of each period. Config updates are shadowed.
module clk_div_multi #(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = 27,
    parameter int DEFAULT_DIV = 100000000,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] en,
    input  logic              sync_restart,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    input  logic [CNT_W-1:0]  cfg_high,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] cfg_pending
);

    localparam logic [CNT_W-1:0] DEF_N   = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] DEF_H   = CNT_W'(DEFAULT_DIV / 2);
    localparam logic [CNT_W-1:0] MIN_N   = CNT_W'(2);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [CNT_W-1:0] shadow_n_q, shadow_h_q, n_q, h_q, cnt_q;
        logic             run_q, clk_q, tick_q, pend_q;

        logic             wr;
        logic [CNT_W-1:0] shadow_n_d, shadow_h_d, n_new, h_new, cnt_inc;
        logic             boundary;

        // A write landing on a boundary edge feeds straight into the active set (bypass).
        always_comb begin
            wr         = cfg_we && (cfg_ch == CH_W'(i));
            shadow_n_d = wr ? cfg_div  : shadow_n_q;
            shadow_h_d = wr ? cfg_high : shadow_h_q;
            n_new      = (shadow_n_d < MIN_N) ? MIN_N : shadow_n_d;
            h_new      = (shadow_h_d > n_new) ? n_new : shadow_h_d;
            cnt_inc    = cnt_q + CNT_ONE;
            boundary   = sync_restart || !run_q || (cnt_q == n_q - CNT_ONE);
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                shadow_n_q <= DEF_N;
                shadow_h_q <= DEF_H;
                n_q        <= DEF_N;
                h_q        <= DEF_H;
                cnt_q      <= '0;
                run_q      <= 1'b0;
                clk_q      <= 1'b0;
                tick_q     <= 1'b0;
                pend_q     <= 1'b0;
            end else begin
                shadow_n_q <= shadow_n_d;
                shadow_h_q <= shadow_h_d;
                if (!en[i]) begin
                    run_q  <= 1'b0;
                    cnt_q  <= '0;
                    tick_q <= 1'b0;
                    clk_q  <= 1'b0;
                    pend_q <= pend_q | wr;
                end else if (boundary) begin
                    run_q  <= 1'b1;
                    cnt_q  <= '0;
                    n_q    <= n_new;
                    h_q    <= h_new;
                    tick_q <= 1'b1;
                    clk_q  <= (h_new != '0);
                    pend_q <= 1'b0;
                end else begin
                    cnt_q  <= cnt_inc;
                    tick_q <= 1'b0;
                    clk_q  <= (cnt_inc < h_q);
                    pend_q <= pend_q | wr;
                end
            end
        end

        assign clk_out[i]     = clk_q;
        assign tick[i]        = tick_q;
        assign cfg_pending[i] = pend_q;
    end

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed and randomized checks of clk_div_multi against a period-start-time reference
// model; a second three-channel instance covers out-of-range channel writes.
module tb_clk_div_multi;

    localparam int NCH = 2;
    localparam int W   = 8;
    localparam int DEF = 10;

    logic           clk = 1'b0;
    logic           reset;
    logic [NCH-1:0] en;
    logic           sync_restart;
    logic           cfg_we;
    logic [0:0]     cfg_ch;
    logic [W-1:0]   cfg_div, cfg_high;
    logic [NCH-1:0] clk_out, tick, cfg_pending;

    logic [2:0]     en3;
    logic           sync3;
    logic           we3;
    logic [1:0]     ch3;
    logic [2:0]     clk_out3, tick3, pend3;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: each running channel remembers the cycle its period began.
    int       t;
    bit       m_run[NCH];
    int       m_start[NCH];
    int       m_n[NCH], m_h[NCH], m_sn[NCH], m_sh[NCH];
    bit       m_pend[NCH];
    bit [1:0] m_clk, m_tick;

    clk_div_multi #(.NUM_CH(NCH), .CNT_W(W), .DEFAULT_DIV(DEF)) u_dut (
        .clk(clk), .reset(reset), .en(en), .sync_restart(sync_restart),
        .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_div(cfg_div), .cfg_high(cfg_high),
        .clk_out(clk_out), .tick(tick), .cfg_pending(cfg_pending)
    );

    clk_div_multi #(.NUM_CH(3), .CNT_W(W), .DEFAULT_DIV(DEF)) u_dut3 (
        .clk(clk), .reset(reset), .en(en3), .sync_restart(sync3),
        .cfg_we(we3), .cfg_ch(ch3), .cfg_div(cfg_div), .cfg_high(cfg_high),
        .clk_out(clk_out3), .tick(tick3), .cfg_pending(pend3)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        t = 0;
        for (int i = 0; i < NCH; i++) begin
            m_run[i] = 0; m_start[i] = 0; m_pend[i] = 0;
            m_n[i] = DEF; m_h[i] = DEF / 2; m_sn[i] = DEF; m_sh[i] = DEF / 2;
        end
        m_clk = '0;
        m_tick = '0;
    endfunction

    function automatic void model_step();
        bit wr;
        int pos;
        t++;
        for (int i = 0; i < NCH; i++) begin
            wr = cfg_we && (int'(cfg_ch) == i);
            if (wr) begin
                m_sn[i] = int'(cfg_div);
                m_sh[i] = int'(cfg_high);
            end
            if (!en[i]) begin
                m_run[i] = 0;
                m_pend[i] = m_pend[i] | wr;
                m_tick[i] = 0;
                m_clk[i] = 0;
            end else begin
                if (sync_restart || !m_run[i] || (t - m_start[i] == m_n[i])) begin
                    m_n[i] = (m_sn[i] < 2) ? 2 : m_sn[i];
                    m_h[i] = (m_sh[i] > m_n[i]) ? m_n[i] : m_sh[i];
                    m_start[i] = t;
                    m_run[i] = 1;
                    m_pend[i] = 0;
                end else begin
                    m_pend[i] = m_pend[i] | wr;
                end
                pos = t - m_start[i];
                m_tick[i] = (pos == 0);
                m_clk[i] = (pos < m_h[i]);
            end
        end
    endfunction

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        chk("clk_out", 32'(clk_out), 32'(m_clk));
        chk("tick", 32'(tick), 32'(m_tick));
        chk("cfg_pending", 32'(cfg_pending), 32'({m_pend[1], m_pend[0]}));
    endtask

    task automatic write0(input logic [W-1:0] d, input logic [W-1:0] h);
        cfg_we = 1'b1; cfg_ch = 1'b0; cfg_div = d; cfg_high = h;
        cyc();
        cfg_we = 1'b0;
    endtask

    // Cycles until the next edge is a wrap of channel 0; a missed bound is a failure.
    task automatic align_wrap0();
        for (int k = 0; k < 40 && (t + 1 - m_start[0] != m_n[0]); k++) cyc();
        chk("wrap_align", 32'(t + 1 - m_start[0] == m_n[0]), 32'd1);
    endtask

    initial begin
        int tk0, hi0, tk1, hi1, bad1;
        reset = 1'b1; en = '0; sync_restart = 1'b0; cfg_we = 1'b0; cfg_ch = '0;
        cfg_div = '0; cfg_high = '0; en3 = '0; sync3 = 1'b0; we3 = 1'b0; ch3 = '0;
        model_reset();
        #12;
        chk("reset_clk_out", 32'(clk_out), 32'd0);
        chk("reset_tick", 32'(tick), 32'd0);
        chk("reset_pending", 32'(cfg_pending), 32'd0);

        en = 2'b01;
        @(negedge clk);
        reset = 1'b0;
        tk0 = 0; hi0 = 0; bad1 = 0;
        for (int k = 0; k < 40; k++) begin
            cyc();
            tk0 += int'(tick[0]); hi0 += int'(clk_out[0]);
            bad1 += int'(tick[1] | clk_out[1]);
        end
        chk("default_ticks", 32'(tk0), 32'd4);
        chk("default_high", 32'(hi0), 32'd20);
        chk("ch1_idle", 32'(bad1), 32'd0);

        // Mid-period write: pending until the wrap, then period 4 with one high cycle.
        cyc(); cyc(); cyc();
        write0(8'd4, 8'd1);
        chk("pend_mid", 32'(cfg_pending[0]), 32'd1);
        for (int k = 0; k < 6; k++) cyc();
        chk("pend_hold", 32'(cfg_pending[0]), 32'd1);
        cyc();
        chk("wrap_tick", 32'(tick[0]), 32'd1);
        chk("wrap_pend", 32'(cfg_pending[0]), 32'd0);
        chk("wrap_high", 32'(clk_out[0]), 32'd1);
        cyc();
        chk("new_low", 32'(clk_out[0]), 32'd0);
        for (int k = 0; k < 10; k++) cyc();

        // Write on the wrap edge: bypass, pending stays clear; H clamps to N.
        align_wrap0();
        write0(8'd6, 8'd200);
        chk("bypass_pend", 32'(cfg_pending[0]), 32'd0);
        chk("bypass_tick", 32'(tick[0]), 32'd1);
        tk0 = 0; hi0 = 0;
        for (int k = 0; k < 12; k++) begin
            cyc();
            tk0 += int'(tick[0]); hi0 += int'(clk_out[0]);
        end
        chk("clamp_ticks", 32'(tk0), 32'd2);
        chk("clamp_high", 32'(hi0), 32'd12);

        align_wrap0();
        write0(8'd1, 8'd1);
        tk0 = 0; hi0 = 0;
        for (int k = 0; k < 8; k++) begin
            cyc();
            tk0 += int'(tick[0]); hi0 += int'(clk_out[0]);
        end
        chk("div1_ticks", 32'(tk0), 32'd4);
        chk("div1_high", 32'(hi0), 32'd4);
        write0(8'd0, 8'd0);
        for (int k = 0; k < 8; k++) cyc();

        // Two channels with different phases, then a common restart.
        write0(8'd7, 8'd3);
        en = 2'b11;
        for (int k = 0; k < 13; k++) cyc();
        sync_restart = 1'b1;
        cyc();
        sync_restart = 1'b0;
        chk("sync_tick", 32'(tick), 32'd3);
        chk("sync_clk", 32'(clk_out), 32'd3);
        for (int k = 0; k < 10; k++) cyc();

        en = 2'b01; sync_restart = 1'b1; we3 = 1'b1; ch3 = 2'd3; cfg_div = 8'd5; cfg_high = 8'd2;
        cyc();
        sync_restart = 1'b0;
        chk("sync_en0_tick", 32'(tick), 32'd1);
        chk("sync_en0_clk", 32'(clk_out), 32'd1);
        chk("ch3_ignored", 32'(pend3), 32'd0);
        ch3 = 2'd2;
        cyc();
        we3 = 1'b0;
        chk("ch2_write", 32'(pend3), 32'd4);

        // Drop enable in the high phase, then re-raise it.
        for (int k = 0; k < 10 && !m_tick[0]; k++) cyc();
        chk("tick_seen", 32'(m_tick[0]), 32'd1);
        cyc();
        chk("in_high", 32'(clk_out[0]), 32'd1);
        en = 2'b00;
        cyc();
        chk("stop_clk", 32'(clk_out), 32'd0);
        chk("stop_tick", 32'(tick), 32'd0);
        en = 2'b01;
        cyc();
        chk("restart_tick", 32'(tick), 32'd1);
        chk("restart_clk", 32'(clk_out), 32'd1);

        for (int k = 0; k < 300; k++) begin
            en[0] = ($urandom_range(0, 15) != 0);
            en[1] = ($urandom_range(0, 15) != 0);
            sync_restart = ($urandom_range(0, 19) == 0);
            cfg_we = ($urandom_range(0, 3) == 0);
            cfg_ch = 1'($urandom_range(0, 1));
            cfg_div = 8'($urandom_range(0, 12));
            cfg_high = 8'($urandom_range(0, 14));
            cyc();
        end
        sync_restart = 1'b0; cfg_we = 1'b0;

        // Asynchronous reset in mid-count with a pending write on the stopped channel.
        en = 2'b01;
        cfg_we = 1'b1; cfg_ch = 1'b1; cfg_div = 8'd5; cfg_high = 8'd2;
        cyc();
        cfg_we = 1'b0;
        chk("pend_stopped", 32'(cfg_pending[1]), 32'd1);
        for (int k = 0; k < 3; k++) cyc();
        #2;
        reset = 1'b1;
        #1;
        chk("async_clk", 32'(clk_out), 32'd0);
        chk("async_tick", 32'(tick), 32'd0);
        chk("async_pend", 32'(cfg_pending), 32'd0);
        model_reset();
        en = 2'b11;
        @(negedge clk);
        reset = 1'b0;
        tk0 = 0; hi0 = 0; tk1 = 0; hi1 = 0;
        for (int k = 0; k < 30; k++) begin
            cyc();
            tk0 += int'(tick[0]); hi0 += int'(clk_out[0]);
            tk1 += int'(tick[1]); hi1 += int'(clk_out[1]);
        end
        chk("post_ticks0", 32'(tk0), 32'd3);
        chk("post_high0", 32'(hi0), 32'd15);
        chk("post_ticks1", 32'(tk1), 32'd3);
        chk("post_high1", 32'(hi1), 32'd15);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
